// File: rtl/dot_clock_pkg.sv
// Shared constants for the VGA dot clock generator: default 14/15 ratio, lock delay
// and the Gowin rPLL divider settings used when DOT_CLOCK_PLL_EN is defined.
package dot_clock_pkg;

  localparam int DOT_NUM        = 14;
  localparam int DOT_DEN        = 15;
  localparam int DOT_LOCK_DELAY = 16;

  // rPLL output = 27 MHz * (FBDIV_SEL+1) / (IDIV_SEL+1) = 25.2 MHz, VCO at 806.4 MHz
  localparam int PLL_IDIV_SEL   = 14;
  localparam int PLL_FBDIV_SEL  = 13;
  localparam int PLL_ODIV_SEL   = 32;

endpackage

// File: rtl/dot_clock_gen_clock_gate.sv
// Latch-based integrated clock gate: enable is captured while clk is low so gclk
// only ever passes whole high phases; reset clears the latch and may truncate one.
module clock_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic gclk
);

  logic en_latch;

  // A vendor ICG cell can replace this latch/AND pair without changing behaviour.
  always_latch begin
    if (!rst_n) begin
      en_latch = 1'b0;
    end else if (!clk) begin
      en_latch = en;
    end
  end

  assign gclk = clk & en_latch;

endmodule

// File: rtl/dot_clock_gen.sv
// VGA dot clock from the 27 MHz oscillator: glitch-free pulse swallowing at NUM/DEN
// by default, or a Gowin rPLL wrapper when DOT_CLOCK_PLL_EN is defined.
module dot_clock_gen
  import dot_clock_pkg::*;
#(
  parameter int NUM        = DOT_NUM,
  parameter int DEN        = DOT_DEN,
  parameter int LOCK_DELAY = DOT_LOCK_DELAY
) (
  input  logic Mhz27,
  input  logic rst_n,
  output logic dotclock,
  output logic dot_ce,
  output logic locked
);

  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       int_rst_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge Mhz27 or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign int_rst_n = rst_sync_q[1];

`ifdef DOT_CLOCK_PLL_EN

  logic       pll_clkout;
  logic       pll_lock;
  logic [1:0] pll_lock_q;
  logic [1:0] pll_lock_d;

  rPLL #(
    .FCLKIN    ("27"),
    .IDIV_SEL  (PLL_IDIV_SEL),
    .FBDIV_SEL (PLL_FBDIV_SEL),
    .ODIV_SEL  (PLL_ODIV_SEL)
  ) u_rpll (
    .CLKOUT   (pll_clkout),
    .LOCK     (pll_lock),
    .CLKOUTP  (),
    .CLKOUTD  (),
    .CLKOUTD3 (),
    .RESET    (!rst_n),
    .RESET_P  (1'b0),
    .CLKIN    (Mhz27),
    .CLKFB    (1'b0),
    .FBDSEL   (6'b000000),
    .IDSEL    (6'b000000),
    .ODSEL    (6'b000000),
    .PSDA     (4'b0000),
    .DUTYDA   (4'b0000),
    .FDLY     (4'b0000)
  );

  always_comb begin
    pll_lock_d = {pll_lock_q[0], pll_lock};
  end

  always_ff @(posedge Mhz27 or negedge rst_n) begin
    if (!rst_n) begin
      pll_lock_q <= 2'b00;
    end else begin
      pll_lock_q <= pll_lock_d;
    end
  end

  assign dotclock = pll_clkout;
  assign dot_ce   = 1'b1;
  assign locked   = pll_lock_q[1] & int_rst_n;

`else

  localparam int ACC_W = $clog2(DEN) + 1;
  localparam int CNT_W = $clog2(LOCK_DELAY + 1);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;
  logic             dot_ce_q;
  logic             dot_ce_d;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [CNT_W-1:0] lock_cnt_d;

  // Bresenham step: one enable per DEN crossing yields exactly NUM enables per DEN cycles.
  always_comb begin
    sum      = acc_q + ACC_W'(NUM);
    acc_d    = '0;
    dot_ce_d = 1'b0;
    if (int_rst_n) begin
      if (sum >= ACC_W'(DEN)) begin
        dot_ce_d = 1'b1;
        acc_d    = sum - ACC_W'(DEN);
      end else begin
        acc_d    = sum;
      end
    end
  end

  always_comb begin
    lock_cnt_d = '0;
    if (int_rst_n) begin
      lock_cnt_d = lock_cnt_q;
      if (lock_cnt_q != CNT_W'(LOCK_DELAY)) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Mhz27 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      dot_ce_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      dot_ce_q   <= dot_ce_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  clock_gate u_gate (
    .clk   (Mhz27),
    .rst_n (rst_n),
    .en    (dot_ce_q),
    .gclk  (dotclock)
  );

  assign dot_ce = dot_ce_q;
  assign locked = (lock_cnt_q == CNT_W'(LOCK_DELAY));

`endif

endmodule

// File: tb/tb_dot_clock_gen.sv
// Directed bench for dot_clock_gen: defaults (14/15), NUM=DEN=15 and NUM=1/DEN=4 instances.
`timescale 1ns/1ps
module tb_dot_clock_gen;

  logic Mhz27 = 1'b0;
  logic rst_n = 1'b0;

  logic dclk_def, ce_def, lk_def;
  logic dclk_eq,  ce_eq,  lk_eq;
  logic dclk_q,   ce_q,   lk_q;

  int checks = 0;
  int errors = 0;

  int rise_def = 0;
  int rise_eq  = 0;
  int rise_q   = 0;
  int bad_pulse = 0;
  bit allow_trunc = 1'b0;
  realtime t_rise = 0.0;

  typedef struct {
    int   n;
    logic ce_def;
    logic ce_q;
    logic ce_eq;
    logic lk;
  } vec_t;

  vec_t vecs[13];

  always #10 Mhz27 = ~Mhz27;

  dot_clock_gen dut (
    .Mhz27    (Mhz27),
    .rst_n    (rst_n),
    .dotclock (dclk_def),
    .dot_ce   (ce_def),
    .locked   (lk_def)
  );

  dot_clock_gen #(.NUM(15), .DEN(15)) dut_eq (
    .Mhz27    (Mhz27),
    .rst_n    (rst_n),
    .dotclock (dclk_eq),
    .dot_ce   (ce_eq),
    .locked   (lk_eq)
  );

  dot_clock_gen #(.NUM(1), .DEN(4)) dut_q (
    .Mhz27    (Mhz27),
    .rst_n    (rst_n),
    .dotclock (dclk_q),
    .dot_ce   (ce_q),
    .locked   (lk_q)
  );

  // Rising-edge counters and full-high-phase width check on the default instance.
  always @(posedge dclk_def) begin
    rise_def++;
    t_rise = $realtime;
  end
  always @(posedge dclk_eq) rise_eq++;
  always @(posedge dclk_q)  rise_q++;
  always @(negedge dclk_def) begin
    if (!allow_trunc && ($realtime - t_rise) != 10.0) bad_pulse++;
  end

  task automatic applyStimulus(input logic rst_val);
    rst_n = rst_val;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Release reset on a low phase and walk edge n = 1..last_n after rst_n rises.
  task automatic runRelease(input int last_n, input bit check_counts);
    int lock_drop;
    int eq_bad;
    lock_drop = 0;
    eq_bad    = 0;
    @(negedge Mhz27);
    rise_def = 0;
    rise_eq  = 0;
    rise_q   = 0;
    applyStimulus(1'b1);
    for (int n = 1; n <= last_n; n++) begin
      @(posedge Mhz27);
      #1;
      foreach (vecs[i]) begin
        if (vecs[i].n == n) begin
          checkOutput($sformatf("ce_def@%0d", n), int'(ce_def), int'(vecs[i].ce_def));
          checkOutput($sformatf("ce_q@%0d", n),   int'(ce_q),   int'(vecs[i].ce_q));
          checkOutput($sformatf("ce_eq@%0d", n),  int'(ce_eq),  int'(vecs[i].ce_eq));
          checkOutput($sformatf("locked@%0d", n), int'(lk_def), int'(vecs[i].lk));
        end
      end
      if (n >= 18 && lk_def !== 1'b1) lock_drop++;
      if (n >= 4 && dclk_eq !== Mhz27) eq_bad++;
    end
    if (check_counts) begin
      checkOutput("rises_default", rise_def, 140);
      checkOutput("rises_quarter", rise_q, 37);
      checkOutput("rises_equal", rise_eq, 150);
      checkOutput("locked_stays_high", lock_drop, 0);
      checkOutput("equal_follows_clk", eq_bad, 0);
      checkOutput("full_pulses", bad_pulse, 0);
    end
  endtask

  initial begin
    int hold_bad;
    int found;
    int rises_before;

    vecs[0]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{5,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{6,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{7,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{10, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{17, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{18, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{19, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{33, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{34, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset hold: nothing may move for 10 cycles.
    applyStimulus(1'b0);
    hold_bad = 0;
    rise_def = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Mhz27);
      #1;
      if (dclk_def !== 1'b0 || ce_def !== 1'b0 || lk_def !== 1'b0) hold_bad++;
      @(posedge Mhz27);
      #1;
      if (dclk_def !== 1'b0 || ce_def !== 1'b0 || lk_def !== 1'b0) hold_bad++;
    end
    checkOutput("reset_hold_outputs", hold_bad, 0);
    checkOutput("reset_hold_rises", rise_def, 0);

    runRelease(153, 1'b1);

    // Mid-operation reset while a gated high phase is in progress.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(posedge Mhz27);
      #2;
      if (dclk_def === 1'b1) found = 1;
    end
    checkOutput("found_high_pulse", found, 1);
    allow_trunc = 1'b1;
    applyStimulus(1'b0);
    #1;
    checkOutput("midreset_dotclock", int'(dclk_def), 0);
    checkOutput("midreset_locked", int'(lk_def), 0);
    checkOutput("midreset_dot_ce", int'(ce_def), 0);
    rises_before = rise_def;
    for (int i = 0; i < 5; i++) @(negedge Mhz27);
    checkOutput("midreset_no_edges", rise_def - rises_before, 0);
    allow_trunc = 1'b0;

    runRelease(34, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000 ns");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dot_clock_gen.md
# dot_clock_gen

Produces the VGA pixel (dot) clock from the 27 MHz board oscillator for the 640x480@60 timing generator. Nominal dot clock is 25.2 MHz, ratio 14/15 of the input. By default this is a glitch-free pulse-swallowing clock whose average frequency is exact. Optionally the block wraps the Gowin rPLL for a true periodic 25.2 MHz clock. Sits between the oscillator pin and all pixel-domain logic.

## Interface
- NUM, 14: enabled input cycles per DEN-cycle frame; 1 ≤ NUM ≤ DEN.
- DEN, 15: frame length in input cycles; DEN ≥ 1, ≤ 255.
- LOCK_DELAY, 16: input cycles after internal reset release before `locked` asserts; ≥ 1.
- Mhz27  in  1  27 MHz reference clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dotclock  out  1  dot clock (gated Mhz27, or PLL output).
- dot_ce  out  1  registered clock enable in the Mhz27 domain; high in cycles whose next Mhz27 high phase is passed to dotclock.
- locked  out  1  dot clock valid and stable.

## Operation
- Reset: rst_n asserts asynchronously. Internal reset releases through a 2-flop synchronizer, so it deasserts on the 2nd Mhz27 rising edge after rst_n rises.
- While in reset: acc=0, dot_ce=0, gate latch=0, dotclock=0 (held low, no pulses), locked=0, lock counter=0.
- Bresenham accumulator runs on each rising edge out of reset:
  - acc width = clog2(DEN)+1 bits.
  - sum = acc + NUM.
  - If sum ≥ DEN: dot_ce←1, acc←sum−DEN.
  - Otherwise: dot_ce←0, acc←sum.
- Every DEN consecutive cycles contain exactly NUM cycles with dot_ce=1.
  - With defaults, starting from acc=0, the first post-reset dot_ce is 0, then 14 ones, then repeating 0 followed by 14 ones.
- NUM==DEN: dot_ce constant 1 after the first edge out of reset, so dotclock equals Mhz27.
- Clock gate:
  - Latch is transparent while Mhz27 is low and captures dot_ce.
  - dotclock = Mhz27 AND latch.
  - No runt pulses and no glitches, including at reset assertion mid-pulse. Async reset clears the latch; a truncated high phase is allowed, a glitch is not.
- locked: lock counter increments each cycle out of reset, saturates at LOCK_DELAY, and locked = (counter == LOCK_DELAY). Reset mid-operation drops locked immediately and asynchronously.

## Timing
- dot_ce registered at edge k gates the Mhz27 high phase that starts at edge k+1. One-cycle gate latency.
- Average dotclock = 27 MHz × NUM/DEN = 25.2 MHz exactly. Worst-case period with defaults is 74.07 ns, with one swallowed cycle per 15.
- locked rises on the LOCK_DELAY-th edge after internal reset release. That is LOCK_DELAY+2 edges after rst_n rises.
- Combinational path from Mhz27 to dotclock is one AND gate. dotclock must be constrained as a generated clock (divide 1, source Mhz27).

## Configuration
- DOT_CLOCK_PLL_EN defined:
  - Instantiates Gowin rPLL with IDIV_SEL=14, FBDIV_SEL=13, ODIV_SEL=32, for 27×14/15 = 25.2 MHz at a VCO of 806.4 MHz.
  - dotclock = PLL CLKOUT.
  - PLL RESET = !rst_n.
  - locked = PLL LOCK, synchronized by 2 flops in the Mhz27 domain, ANDed with internal reset released.
  - dot_ce tied to 1.
  - Accumulator and gate are not built. NUM and DEN are ignored.
- Not defined: pulse-swallowing behaviour as described above.

## Structure
- Package dot_clock_pkg holds:
  - DOT_NUM=14, DOT_DEN=15, DOT_LOCK_DELAY=16.
  - PLL constants PLL_IDIV_SEL=14, PLL_FBDIV_SEL=13, PLL_ODIV_SEL=32.
- One sub-module, clock_gate: latch-based integrated clock gate with ports clk, rst_n, en, gclk. Use the vendor ICG primitive when available.

## Test plan
- Reset hold: rst_n=0 for 10 cycles → dotclock=0, dot_ce=0, locked=0 throughout, with no dotclock edges.
- Release, defaults: over 150 input cycles after sync release, dot_ce pattern is 0 then 14×1, repeating. Exactly 140 dotclock rising edges. Every dotclock high pulse is a full Mhz27 high phase.
- Lock timing: rst_n rises → locked=1 exactly on the 18th Mhz27 rising edge, and stays high.
- Mid-operation reset: assert rst_n while Mhz27 is high and dot_ce=1 → dotclock falls at once with no glitch, and locked=0 immediately. After re-release the pattern restarts from acc=0.
- NUM=DEN=15: dotclock toggles identically to Mhz27 from the 2nd post-release cycle, with zero swallowed cycles over 100 cycles.
- NUM=1, DEN=4: exactly one dotclock pulse per 4 input cycles. Pulses occur in the 5th, 9th, and 13th gated high phases post-release (acc 0→1→2→3→0).
